// File: rtl/lane_writeback.sv
// rtl/lane_writeback.sv - in-order lane result buffer feeding the vector register file
// Per-register pending counters let issue logic see hazards on still-buffered results.
module lane_writeback #(
   parameter int VECTOR_REG_WIDTH  = 64,
   parameter int NUM_OF_VECTOR_REG = 32,
   parameter int WB_DEPTH          = 4,
   localparam int RW = $clog2(NUM_OF_VECTOR_REG),
   localparam int CW = $clog2(WB_DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         result_vld,
   input  logic [RW-1:0]                vec_reg_out,
   input  logic [VECTOR_REG_WIDTH-1:0]  data_out,
   output logic                         wb_full_lane,
   input  logic                         flush,
   output logic                         rf_wr_en,
   output logic [RW-1:0]                rf_wr_addr,
   output logic [VECTOR_REG_WIDTH-1:0]  rf_wr_data,
   input  logic                         rf_wr_ready,
   output logic [NUM_OF_VECTOR_REG-1:0] reg_pending,
   output logic [CW-1:0]                wb_count,
   output logic                         wb_overflow
);

   localparam int PW = $clog2(WB_DEPTH);

   logic [RW-1:0]               addr_mem [WB_DEPTH];
   logic [VECTOR_REG_WIDTH-1:0] data_mem [WB_DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] pend_cnt_q [NUM_OF_VECTOR_REG];
   logic [CW-1:0] pend_cnt_d [NUM_OF_VECTOR_REG];
   logic          overflow_q, overflow_d;

   logic pop_raw, pop, push, has_room;

   assign rf_wr_en     = (count_q != '0);
   assign rf_wr_addr   = addr_mem[rd_ptr_q];
   assign rf_wr_data   = data_mem[rd_ptr_q];
   assign wb_count     = count_q;
   assign wb_overflow  = overflow_q;
   assign wb_full_lane = (count_q >= CW'(WB_DEPTH - 1));

   // A pop frees the head slot in the same cycle, so a full buffer still takes a push then.
   assign has_room = (count_q < CW'(WB_DEPTH));
   assign pop_raw  = rf_wr_en & rf_wr_ready;
   assign pop      = pop_raw & ~flush;
   assign push     = result_vld & (has_room | pop_raw) & ~flush;

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (result_vld & ~has_room & ~pop_raw);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_OF_VECTOR_REG; r++) begin
         pend_cnt_d[r] = pend_cnt_q[r];
         if (flush) begin
            pend_cnt_d[r] = '0;
         end else begin
            if (push && vec_reg_out == RW'(r)) pend_cnt_d[r] = pend_cnt_d[r] + CW'(1);
            if (pop && rf_wr_addr == RW'(r))   pend_cnt_d[r] = pend_cnt_d[r] - CW'(1);
         end
         reg_pending[r] = (pend_cnt_q[r] != '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int r = 0; r < NUM_OF_VECTOR_REG; r++) pend_cnt_q[r] <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         for (int r = 0; r < NUM_OF_VECTOR_REG; r++) pend_cnt_q[r] <= pend_cnt_d[r];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= vec_reg_out;
         data_mem[wr_ptr_q] <= data_out;
      end
   end

endmodule
